// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 8x8 reg_file: round-robin grant between writeback
// sources, with an optional locked burst bounded by a watchdog.
module regfile_wr_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOCK_MAX = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic                        rf_wr_en,
  output logic [ADDR_W-1:0]           rf_write_addr,
  output logic [DATA_W-1:0]           rf_write_val,
  output logic                        locked,
  output logic [$clog2(NUM_REQ)-1:0]  lock_owner,
  output logic                        lock_timeout
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           timeout_q, timeout_d;

  logic           gnt_any;
  logic [PW-1:0]  gnt_idx;
  logic [PW-1:0]  cand;

  // Grant selection: owner-only while locked, otherwise first valid from rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (state_q == LOCKED) begin
      if (req_valid[owner_q]) begin
        gnt_any = 1'b1;
        gnt_idx = owner_q;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = PW'((32'(rr_ptr_q) + k) % NUM_REQ);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (reset) gnt_any = 1'b0;
  end

  always_comb begin
    req_grant     = '0;
    rf_wr_en      = gnt_any;
    rf_write_addr = '0;
    rf_write_val  = '0;
    if (gnt_any) begin
      req_grant[gnt_idx] = 1'b1;
      rf_write_addr      = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
      rf_write_val       = req_data[32'(gnt_idx)*DATA_W +: DATA_W];
    end
  end

  // Next state: lock entry, normal release, watchdog release.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (gnt_any) rr_ptr_d = PW'((32'(gnt_idx) + 1) % NUM_REQ);
    case (state_q)
      IDLE: begin
        if (gnt_any && req_lock[gnt_idx]) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (cnt_q != CW'(LOCK_MAX)) cnt_d = cnt_q + CW'(1);
        if (!req_lock[owner_q]) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(LOCK_MAX - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign lock_owner   = owner_q;
  assign lock_timeout = timeout_q;

endmodule
